bus_select_arbiter: RTL and testbench



---
 rtl/bus_select_arbiter_if.sv | 21 ++
 rtl/bus_select_arbiter.sv | 103 ++++++++++
 tb/tb_bus_select_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bus_select_arbiter_if.sv
// Request/grant bundle between the two bus sources and the bus_select_arbiter.
// The master side is the requesting sources; the slave side is the arbiter.
interface bus_select_arbiter_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic bus_sel;
  logic bus_en;
  logic busy;

  modport master (
    output req_a, req_b,
    input  gnt_a, gnt_b, bus_sel, bus_en, busy
  );

  modport slave (
    input  req_a, req_b,
    output gnt_a, gnt_b, bus_sel, bus_en, busy
  );
endinterface

// File: rtl/bus_select_arbiter.sv
// Two-source round-robin arbiter producing select/enable for the tristate bus mux.
// Source A drives the in1 leg (bus_sel = 1), source B the in2 leg (bus_sel = 0).
// Bursts are bounded while the other source waits, and every release is followed
// by TURN_CYCLES idle cycles so the two buffer legs never overlap.
module bus_select_arbiter #(
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_select_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [3:0] BURST_SAT  = 4'(MAX_BURST);
  localparam logic [1:0] TURN_LAST  = 2'(TURN_CYCLES - 1);

  state_t     state;
  logic       owner;      // 0 = A, 1 = B
  logic       prio;       // preferred source on contention, 0 = A
  logic [3:0] burst_cnt;
  logic [1:0] turn_cnt;

  logic own_req;
  logic other_req;
  logic release_bus;
  logic arb_now;
  logic arb_any;
  logic arb_pick;

  // Decode request levels relative to the current owner and the arbitration choice.
  always_comb begin
    own_req     = owner ? bus.req_b : bus.req_a;
    other_req   = owner ? bus.req_a : bus.req_b;
    release_bus = ~own_req | ((burst_cnt >= BURST_LAST) & other_req);
    arb_now     = (state == IDLE) | ((state == TURN) & (turn_cnt == TURN_LAST));
    arb_any     = bus.req_a | bus.req_b;
    arb_pick    = (bus.req_a & bus.req_b) ? prio : ~bus.req_a;
  end

  // Ownership FSM with registered grant, select, enable and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      prio        <= 1'b0;
      burst_cnt   <= 4'd0;
      turn_cnt    <= 2'd0;
      bus.gnt_a   <= 1'b0;
      bus.gnt_b   <= 1'b0;
      bus.bus_sel <= 1'b0;
      bus.bus_en  <= 1'b0;
      bus.busy    <= 1'b0;
    end else if (arb_now) begin
      if (arb_any) begin
        state       <= OWN;
        owner       <= arb_pick;
        burst_cnt   <= 4'd0;
        bus.gnt_a   <= ~arb_pick;
        bus.gnt_b   <= arb_pick;
        bus.bus_sel <= ~arb_pick;
        bus.bus_en  <= 1'b1;
        bus.busy    <= 1'b1;
      end else begin
        // Nobody asking: park in IDLE, bus_sel keeps its last value.
        state      <= IDLE;
        bus.gnt_a  <= 1'b0;
        bus.gnt_b  <= 1'b0;
        bus.bus_en <= 1'b0;
        bus.busy   <= 1'b0;
      end
    end else begin
      case (state)
        OWN: begin
          if (release_bus) begin
            state      <= TURN;
            prio       <= ~owner;
            turn_cnt   <= 2'd0;
            bus.gnt_a  <= 1'b0;
            bus.gnt_b  <= 1'b0;
            bus.bus_en <= 1'b0;
            bus.busy   <= 1'b1;
          end else if (burst_cnt != BURST_SAT) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        TURN: begin
          turn_cnt <= turn_cnt + 2'd1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Scoreboard bench for bus_select_arbiter: two instances (TURN_CYCLES = 1 and 3)
// share one request stream; a behavioural model predicts each cycle's outputs.
module tb_bus_select_arbiter;

  localparam int MB   = 4;
  localparam int TC_1 = 1;
  localparam int TC_3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic req_a;
  logic req_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_select_arbiter_if if1 ();
  bus_select_arbiter_if if3 ();

  assign if1.req_a = req_a;
  assign if1.req_b = req_b;
  assign if3.req_a = req_a;
  assign if3.req_b = req_b;

  bus_select_arbiter #(.MAX_BURST(MB), .TURN_CYCLES(TC_1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  bus_select_arbiter #(.MAX_BURST(MB), .TURN_CYCLES(TC_3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  // Reference model: who owns the bus, how long it has held it, idle gap left.
  typedef struct packed {
    int   owner;  // -1 none, 0 A, 1 B
    int   held;   // grant cycles completed by the current owner
    int   gap;    // remaining forced-idle cycles
    logic pref;   // 1 = B preferred on contention
    logic sel;
  } mdl_t;

  mdl_t m1 = '{owner: -1, held: 0, gap: 0, pref: 1'b0, sel: 1'b0};
  mdl_t m3 = '{owner: -1, held: 0, gap: 0, pref: 1'b0, sel: 1'b0};

  logic [4:0] q1[$];
  logic [4:0] q3[$];

  function automatic mdl_t step(mdl_t m, logic rst, logic ra, logic rb, int mb, int tc);
    mdl_t n = m;
    logic mine;
    logic other;
    int   pick;
    if (!rst) begin
      n.owner = -1; n.held = 0; n.gap = 0; n.pref = 1'b0; n.sel = 1'b0;
      return n;
    end
    if (m.owner >= 0) begin
      mine  = (m.owner == 0) ? ra : rb;
      other = (m.owner == 0) ? rb : ra;
      if (!mine || (m.held >= mb && other)) begin
        n.pref  = (m.owner == 0);
        n.owner = -1;
        n.gap   = tc;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.gap > 1) begin
      n.gap = m.gap - 1;
    end else begin
      n.gap = 0;
      pick  = -1;
      if (ra && rb)  pick = m.pref ? 1 : 0;
      else if (ra)   pick = 0;
      else if (rb)   pick = 1;
      if (pick >= 0) begin
        n.owner = pick;
        n.held  = 1;
        n.sel   = (pick == 0);
      end
    end
    return n;
  endfunction

  // {gnt_a, gnt_b, bus_sel, bus_en, busy}
  function automatic logic [4:0] outs(mdl_t m);
    return {m.owner == 0, m.owner == 1, m.sel, m.owner >= 0, (m.owner >= 0) || (m.gap > 0)};
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got {ga,gb,sel,en,busy}=%b expected %b", name, $time, act, exp);
  endtask

  // Predict the outputs that appear after each rising edge.
  always @(posedge clk) begin
    m1 = step(m1, rst_n, req_a, req_b, MB, TC_1);
    m3 = step(m3, rst_n, req_a, req_b, MB, TC_3);
    q1.push_back(outs(m1));
    q3.push_back(outs(m3));
  end

  // Monitor: compare DUT outputs mid-cycle against the queued predictions.
  initial begin
    logic [4:0] a1;
    logic [4:0] a3;
    @(posedge clk);
    forever begin
      @(negedge clk);
      a1 = {if1.gnt_a, if1.gnt_b, if1.bus_sel, if1.bus_en, if1.busy};
      a3 = {if3.gnt_a, if3.gnt_b, if3.bus_sel, if3.bus_en, if3.busy};
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL q1_empty t=%0t got no prediction, required one", $time);
      end else chk("dut1_outputs", a1, q1.pop_front());
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL q3_empty t=%0t got no prediction, required one", $time);
      end else chk("dut3_outputs", a3, q3.pop_front());
      chk("dut1_excl", {4'b0, if1.gnt_a & if1.gnt_b}, 5'b0);
      chk("dut3_excl", {4'b0, if3.gnt_a & if3.gnt_b}, 5'b0);
      if (if1.bus_en) chk("dut1_sel_owner", {4'b0, if1.bus_sel}, {4'b0, if1.gnt_a});
      if (if3.bus_en) chk("dut3_sel_owner", {4'b0, if3.bus_sel}, {4'b0, if3.gnt_a});
    end
  end

  task automatic hold(logic a, logic b, int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      req_a = a;
      req_b = b;
    end
  endtask

  // Stimulus: directed phases, then random request patterns.
  initial begin
    rst_n = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    hold(1'b1, 1'b1, 3);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    // Contention: alternating bursts separated by turnaround.
    hold(1'b1, 1'b1, 24);
    // Single source keeps the bus indefinitely.
    hold(1'b0, 1'b1, 12);
    // Early release by A while B waits.
    hold(1'b0, 1'b0, 5);
    hold(1'b1, 1'b0, 1);
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b1, 8);
    // Reset during B's second grant cycle.
    hold(1'b0, 1'b0, 5);
    hold(1'b0, 1'b1, 3);
    rst_n = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    #1;
    chk("dut1_async_rst", {if1.gnt_a, if1.gnt_b, if1.bus_sel, if1.bus_en, if1.busy}, 5'b0);
    chk("dut3_async_rst", {if3.gnt_a, if3.gnt_b, if3.bus_sel, if3.bus_en, if3.busy}, 5'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 1'b1, 12);
    // Random traffic with varied hold lengths.
    repeat (400) begin
      hold(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 8)));
    end
    hold(1'b0, 1'b0, 6);
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
